// File: rtl/eth_log_merger.sv
// Purpose: packet-atomic round-robin merge of log A / log B into one tagged AXI4-Stream.
// Latency: one cycle from input accept to m_axis_tvalid, plus one arbitration bubble per packet.
// Backpressure: only the granted source sees tready, and only while the output register can take a beat.
//
// Ports: clk, rst_n (async active-low), enable (gates new grants only),
//   s_axis_a_* / s_axis_b_* (log sources), m_axis_* (merged stream, tdest 0 = A, 1 = B),
//   overlong (one-cycle pulse when a packet is cut at C_MAX_BEATS).
// Optional: define ETH_LOG_MERGER_STATS_EN to add stats_clear, packets_a, packets_b, truncated_count.
module eth_log_merger #(
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BEATS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [C_AXIS_WIDTH-1:0] s_axis_a_tdata,
  input  logic                    s_axis_a_tlast,
  input  logic                    s_axis_a_tvalid,
  output logic                    s_axis_a_tready,
  input  logic [C_AXIS_WIDTH-1:0] s_axis_b_tdata,
  input  logic                    s_axis_b_tlast,
  input  logic                    s_axis_b_tvalid,
  output logic                    s_axis_b_tready,
  output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tdest,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
`ifdef ETH_LOG_MERGER_STATS_EN
  input  logic                    stats_clear,
  output logic [31:0]             packets_a,
  output logic [31:0]             packets_b,
  output logic [15:0]             truncated_count,
`endif
  output logic                    overlong
);

  localparam int CNT_W = $clog2(C_MAX_BEATS + 1);

  typedef enum logic [2:0] {
    IDLE,
    FWD_A,
    FWD_B,
    DRAIN_A,
    DRAIN_B
  } state_t;

  state_t             state, state_nxt;
  logic               last_grant, last_grant_nxt;   // 0 = A, 1 = B
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;

  logic                    sel_b;
  logic                    fwd;
  logic                    out_free;
  logic                    sel_vld;
  logic                    sel_last;
  logic [C_AXIS_WIDTH-1:0] sel_dat;
  logic                    acc;
  logic                    at_limit;
  logic                    trunc;
  logic                    pkt_end;

  // Source mux: DRAIN_x still handshakes with source x, it just never writes the output.
  always_comb begin
    sel_b    = (state == FWD_B) || (state == DRAIN_B);
    fwd      = (state == FWD_A) || (state == FWD_B);
    out_free = !m_axis_tvalid || m_axis_tready;

    s_axis_a_tready = out_free && ((state == FWD_A) || (state == DRAIN_A));
    s_axis_b_tready = out_free && ((state == FWD_B) || (state == DRAIN_B));

    sel_vld  = sel_b ? s_axis_b_tvalid : s_axis_a_tvalid;
    sel_last = sel_b ? s_axis_b_tlast  : s_axis_a_tlast;
    sel_dat  = sel_b ? s_axis_b_tdata  : s_axis_a_tdata;
    acc      = sel_vld && (sel_b ? s_axis_b_tready : s_axis_a_tready);

    // beat_cnt holds beats already accepted, so this accept is beat number C_MAX_BEATS.
    at_limit = (beat_cnt == CNT_W'(C_MAX_BEATS - 1));
    trunc    = fwd && acc && !sel_last && at_limit;
    pkt_end  = acc && sel_last;
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (enable && (s_axis_a_tvalid || s_axis_b_tvalid)) begin
          if (s_axis_a_tvalid && s_axis_b_tvalid) begin
            state_nxt = last_grant ? FWD_A : FWD_B;
          end else begin
            state_nxt = s_axis_a_tvalid ? FWD_A : FWD_B;
          end
        end
      end
      FWD_A, FWD_B: begin
        if (acc) begin
          if (sel_last) begin
            state_nxt      = IDLE;
            last_grant_nxt = sel_b;
            beat_cnt_nxt   = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
            if (at_limit) begin
              state_nxt = sel_b ? DRAIN_B : DRAIN_A;
            end
          end
        end
      end
      DRAIN_A, DRAIN_B: begin
        if (pkt_end) begin
          state_nxt      = IDLE;
          last_grant_nxt = sel_b;
          beat_cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant resets to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Single output stage; fields only change on a load so they stay stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tdest  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      overlong      <= 1'b0;
    end else begin
      overlong <= trunc;
      if (fwd && acc) begin
        m_axis_tdata  <= sel_dat;
        m_axis_tdest  <= sel_b;
        m_axis_tlast  <= sel_last || at_limit;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef ETH_LOG_MERGER_STATS_EN
  // Packet counts follow the input tlast, so truncated packets count once when their tail drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packets_a       <= '0;
      packets_b       <= '0;
      truncated_count <= '0;
    end else if (stats_clear) begin
      packets_a       <= '0;
      packets_b       <= '0;
      truncated_count <= '0;
    end else begin
      if (pkt_end && !sel_b && (packets_a != '1)) begin
        packets_a <= packets_a + 32'd1;
      end
      if (pkt_end && sel_b && (packets_b != '1)) begin
        packets_b <= packets_b + 32'd1;
      end
      if (trunc && (truncated_count != '1)) begin
        truncated_count <= truncated_count + 16'd1;
      end
    end
  end
`endif

endmodule
